// File: rtl/program_loader.sv
// Framed byte-stream loader that fills instruction memory with 16-bit words.
// Optional trailing checksum byte enabled by defining CHECKSUM_EN.
module program_loader #(
    parameter int          MAX_WORDS  = 256,
    parameter logic [15:0] START_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] mem_data,
    output logic [15:0] mem_addr,
    output logic        mem_wren,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHK, DONE, ERR
    } state_t;

`ifdef CHECKSUM_EN
    localparam state_t END_ST = CHK;
`else
    localparam state_t END_ST = DONE;
`endif

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state, state_nx;
    logic [15:0] count;
    logic [7:0]  hi;
    logic        acc;
    logic [15:0] cnt_full;
    logic        last;

`ifdef CHECKSUM_EN
    logic [7:0] sum;
`endif

    assign acc      = byte_valid && byte_ready;
    assign cnt_full = {count[15:8], byte_in};
    assign last     = (words_loaded + 16'd1) == count;

    always_comb begin
        state_nx   = state;
        byte_ready = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                byte_ready = 1'b1;
                if (acc && byte_in == 8'hA5) state_nx = CNT_HI;
            end
            CNT_HI: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (acc) state_nx = CNT_LO;
            end
            CNT_LO: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (acc) begin
                    if ({1'b0, cnt_full} > MAX_W) state_nx = ERR;
                    else if (cnt_full == 16'd0)  state_nx = END_ST;
                    else                         state_nx = DAT_HI;
                end
            end
            DAT_HI: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (acc) state_nx = DAT_LO;
            end
            DAT_LO: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (acc) state_nx = last ? END_ST : DAT_HI;
            end
            CHK: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
`ifdef CHECKSUM_EN
                if (acc) state_nx = (8'(byte_in + sum) == 8'h00) ? DONE : ERR;
`else
                state_nx = IDLE;
`endif
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            ERR: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= 16'd0;
            hi           <= 8'd0;
            mem_data     <= 16'd0;
            mem_addr     <= START_ADDR;
            mem_wren     <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
`ifdef CHECKSUM_EN
            sum          <= 8'd0;
`endif
        end else begin
            state    <= state_nx;
            mem_wren <= 1'b0;
            if (state_nx == ERR) error <= 1'b1;
            if (acc) begin
                unique case (state)
                    IDLE: if (byte_in == 8'hA5) begin
                        error        <= 1'b0;
                        words_loaded <= 16'd0;
`ifdef CHECKSUM_EN
                        sum          <= 8'd0;
`endif
                    end
                    CNT_HI: count[15:8] <= byte_in;
                    CNT_LO: count[7:0]  <= byte_in;
                    DAT_HI: hi          <= byte_in;
                    DAT_LO: begin
                        mem_data     <= {hi, byte_in};
                        mem_addr     <= START_ADDR + words_loaded;
                        mem_wren     <= 1'b1;
                        words_loaded <= words_loaded + 16'd1;
                    end
                    default: ;
                endcase
`ifdef CHECKSUM_EN
                if (state inside {CNT_HI, CNT_LO, DAT_HI, DAT_LO})
                    sum <= sum + byte_in;
`endif
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: randomized frames vs. a frame-level model.
// START_ADDR is set to 16'hFFFF so address wrap is exercised on every multi-word frame.
module tb_program_loader;

    localparam int          MAXW = 256;
    localparam logic [15:0] SA   = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] mem_data;
    logic [15:0] mem_addr;
    logic        mem_wren;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    program_loader #(.MAX_WORDS(MAXW), .START_ADDR(SA)) dut (
        .clk(clk), .rst(rst),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_data(mem_data), .mem_addr(mem_addr), .mem_wren(mem_wren),
        .cpu_hold(cpu_hold), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct packed {
        logic        is_done;
        logic [15:0] words;
    } ev_t;

    wr_t         wq[$];
    ev_t         eq[$];
    logic [15:0] fixed_words[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic ok;
        byte_in    = b;
        byte_valid = 1'b1;
        n          = 0;
        do begin
            ok = byte_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
    endtask

    // Frame-level model: writes land at SA+i; outcome follows count and checksum.
    task automatic send_frame(input int cnt, input bit bad_ck);
        logic [7:0]  s;
        logic [15:0] w;
        logic [15:0] c16;
        ev_t         ev;
        c16 = 16'(cnt);
        s   = 8'(c16[15:8] + c16[7:0]);
        if (cnt > MAXW) begin
            ev.is_done = 1'b0;
            ev.words   = 16'd0;
        end else begin
`ifdef CHECKSUM_EN
            ev.is_done = !bad_ck;
`else
            ev.is_done = 1'b1;
`endif
            ev.words   = c16;
        end
        eq.push_back(ev);
        send_byte(8'hA5);
        chk("hold_after_hdr", {31'd0, cpu_hold}, 32'd1);
        chk("err_clr_hdr", {31'd0, error}, 32'd0);
        send_byte(c16[15:8]);
        send_byte(c16[7:0]);
        if (cnt > MAXW) return;
        for (int i = 0; i < cnt; i++) begin
            if (fixed_words.size() > 0) w = fixed_words.pop_front();
            else                        w = 16'($urandom);
            wq.push_back('{addr: 16'(SA + 16'(i)), data: w});
            s = 8'(s + w[15:8] + w[7:0]);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
`ifdef CHECKSUM_EN
        if (bad_ck) send_byte(8'(8'd0 - s + 8'(1 + $urandom_range(0, 254))));
        else        send_byte(8'(8'd0 - s));
`endif
    endtask

    task automatic junk();
        logic [7:0] b;
        repeat ($urandom_range(0, 3)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_data"},  {16'd0, mem_data}, 32'd0);
        chk({tag, "_addr"},  {16'd0, mem_addr}, {16'd0, SA});
        chk({tag, "_wren"},  {31'd0, mem_wren}, 32'd0);
        chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
        chk({tag, "_err"},   {31'd0, error}, 32'd0);
        chk({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
        chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd1);
    endtask

    // Monitor: pops expected writes/events as the DUT presents them.
    initial begin : monitor
        logic prev_err;
        wr_t  ew;
        ev_t  ee;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_err = 1'b0;
                continue;
            end
            if (mem_wren) begin
                if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                else begin
                    ew = wq.pop_front();
                    chk("wr_addr", {16'd0, mem_addr}, {16'd0, ew.addr});
                    chk("wr_data", {16'd0, mem_data}, {16'd0, ew.data});
                end
            end
            if (done || (error && !prev_err)) begin
                if (eq.size() == 0) chk("unexpected_event", 32'd1, 32'd0);
                else begin
                    ee = eq.pop_front();
                    chk("ev_kind", {31'd0, done}, {31'd0, ee.is_done});
                    chk("ev_words", {16'd0, words_loaded}, {16'd0, ee.words});
                    if (done) chk("done_hold", {31'd0, cpu_hold}, 32'd0);
                end
            end
            prev_err = error;
        end
    end

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        check_reset_vals("rst");
        send_byte(8'h00);
        send_byte(8'h12);
        idle(2);
        check_reset_vals("junk");

        fixed_words.push_back(16'h1234);
        fixed_words.push_back(16'hABCD);
        send_frame(2, 1'b0);
        idle(4);
        chk("frame_a_words", {16'd0, words_loaded}, 32'd2);

        send_frame(257, 1'b0);
        idle(4);
        chk("ovf_sticky", {31'd0, error}, 32'd1);
        chk("ovf_hold", {31'd0, cpu_hold}, 32'd0);
        chk("ovf_words", {16'd0, words_loaded}, 32'd0);

        send_frame(1, 1'b0);
        idle(4);
        chk("post_ovf_err", {31'd0, error}, 32'd0);

`ifdef CHECKSUM_EN
        fixed_words.push_back(16'h0005);
        send_frame(1, 1'b1);
        idle(4);
        chk("ck_err", {31'd0, error}, 32'd1);
        chk("ck_words", {16'd0, words_loaded}, 32'd1);
`endif

        send_frame(0, 1'b0);
        idle(3);

        for (int k = 0; k < 20; k++) begin
            junk();
            send_frame($urandom_range(0, 8), $urandom_range(0, 3) == 0);
        end
        send_frame(MAXW, 1'b0);
        idle(4);
        chk("max_words", {16'd0, words_loaded}, MAXW);

        // Abandon a frame between the high and low byte of word 1.
        wq.push_back('{addr: SA, data: 16'h1122});
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("midrst");
        idle(4);
        send_frame(2, 1'b0);
        idle(10);

        chk("wq_empty", wq.size(), 32'd0);
        chk("eq_empty", eq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
